// File: rtl/fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fir_coef_ctrl
// Description : Run-time coefficient controller for a transposed-form FIR.
//               Holds a shadow and an active coefficient bank, passes the
//               upstream sample stream through, and on commit stalls the
//               stream, swaps banks atomically and optionally injects
//               TAPS-1 zero beats to flush stale partial sums.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coef_ctrl #(
    parameter int DW       = 24,
    parameter int TAPS     = 8,
    parameter int AW       = 3,
    parameter int FLUSH_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_wr_en,
    input  logic [AW-1:0]        cfg_wr_addr,
    input  logic [DW-1:0]        cfg_wr_data,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic [7:0]           cfg_version,
    input  logic [DW-1:0]        s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DW-1:0]        fir_tdata,
    output logic                 fir_tvalid,
    input  logic                 fir_tready,
    output logic                 fir_tuser,
    output logic [TAPS*DW-1:0]   coef_flat
);

    localparam logic [1:0]    c_RUN   = 2'd0;
    localparam logic [1:0]    c_SWAP  = 2'd1;
    localparam logic [1:0]    c_FLUSH = 2'd2;

    // Flush counter only needs to reach TAPS-2 (the last of TAPS-1 beats).
    localparam int            c_CW       = (TAPS > 2) ? $clog2(TAPS) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(TAPS - 2);

    // Near-unity passthrough value for tap 0 after reset.
    localparam logic [DW-1:0] c_TAP0_RST = {1'b0, {(DW-1){1'b1}}};

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [7:0]      r_version;
    logic [DW-1:0]   r_shadow [TAPS];
    logic [DW-1:0]   r_active [TAPS];

    // Shadow bank: written in any state; out-of-range addresses match no tap.
    always_ff @(posedge clk) begin
        for (int t = 0; t < TAPS; t++) begin
            if (!rst_n) begin
                r_shadow[t] <= (t == 0) ? c_TAP0_RST : '0;
            end else if (cfg_wr_en && (cfg_wr_addr == AW'(t))) begin
                r_shadow[t] <= cfg_wr_data;
            end
        end
    end

    // Active bank: only ever loaded on the single SWAP cycle.
    always_ff @(posedge clk) begin
        for (int t = 0; t < TAPS; t++) begin
            if (!rst_n) begin
                r_active[t] <= (t == 0) ? c_TAP0_RST : '0;
            end else if (r_state == c_SWAP) begin
                r_active[t] <= r_shadow[t];
            end
        end
    end

    // Control FSM with flush beat counter and swap version counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_RUN;
            r_cnt     <= '0;
            r_version <= '0;
        end else begin
            case (r_state)
                c_RUN: begin
                    if (cfg_commit) begin
                        r_state <= c_SWAP;
                    end
                end
                c_SWAP: begin
                    r_version <= r_version + 8'd1;
                    r_cnt     <= '0;
                    r_state   <= (FLUSH_EN != 0) ? c_FLUSH : c_RUN;
                end
                c_FLUSH: begin
                    // fir_tvalid is constant 1 here, so ready alone is the handshake.
                    if (fir_tready) begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= c_RUN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= c_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Stream steering: passthrough in RUN, stall in SWAP, zero beats in FLUSH.
    always_comb begin
        fir_tdata     = '0;
        fir_tvalid    = 1'b0;
        fir_tuser     = 1'b0;
        s_axis_tready = 1'b0;
        case (r_state)
            c_RUN: begin
                fir_tdata     = s_axis_tdata;
                fir_tvalid    = s_axis_tvalid;
                s_axis_tready = fir_tready;
            end
            c_FLUSH: begin
                fir_tvalid = 1'b1;
                fir_tuser  = 1'b1;
            end
            default: begin
                fir_tvalid    = 1'b0;
                s_axis_tready = 1'b0;
            end
        endcase
    end

    assign cfg_busy    = (r_state != c_RUN);
    assign cfg_version = r_version;

    generate
        for (genvar t = 0; t < TAPS; t++) begin : g_flat
            assign coef_flat[t*DW +: DW] = r_active[t];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_coef_ctrl
// Description : Directed self-checking bench for fir_coef_ctrl (DW=12,
//               TAPS=4) with one FLUSH_EN=1 and one FLUSH_EN=0 instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coef_ctrl;

    localparam int DW   = 12;
    localparam int TAPS = 4;
    localparam int AW   = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_wr_en;
    logic [AW-1:0]     cfg_wr_addr;
    logic [DW-1:0]     cfg_wr_data;
    logic              cfg_commit;
    logic              cfg_busy;
    logic [7:0]        cfg_version;
    logic [DW-1:0]     s_axis_tdata;
    logic              s_axis_tvalid;
    logic              s_axis_tready;
    logic [DW-1:0]     fir_tdata;
    logic              fir_tvalid;
    logic              fir_tready;
    logic              fir_tuser;
    logic [TAPS*DW-1:0] coef_flat;

    logic              c0_commit;
    logic              c0_busy;
    logic [7:0]        c0_version;
    logic              c0_s_tready;
    logic [DW-1:0]     c0_fir_tdata;
    logic              c0_fir_tvalid;
    logic              c0_fir_tuser;
    logic [TAPS*DW-1:0] c0_coef_flat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fir_coef_ctrl #(.DW(DW), .TAPS(TAPS), .AW(AW), .FLUSH_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_version(cfg_version),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .fir_tdata(fir_tdata), .fir_tvalid(fir_tvalid), .fir_tready(fir_tready),
        .fir_tuser(fir_tuser), .coef_flat(coef_flat)
    );

    fir_coef_ctrl #(.DW(DW), .TAPS(TAPS), .AW(AW), .FLUSH_EN(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(c0_commit), .cfg_busy(c0_busy), .cfg_version(c0_version),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(c0_s_tready),
        .fir_tdata(c0_fir_tdata), .fir_tvalid(c0_fir_tvalid), .fir_tready(fir_tready),
        .fir_tuser(c0_fir_tuser), .coef_flat(c0_coef_flat)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        int beats;
        int hs;
        logic [DW-1:0] wvals [4];
        wvals[0] = 12'h100; wvals[1] = 12'h200; wvals[2] = 12'h300; wvals[3] = 12'h400;

        rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
        cfg_commit = 1'b0; c0_commit = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; fir_tready = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset defaults and RUN passthrough
        chk("rst_coef", coef_flat, 48'h000_000_000_7FF);
        chk("rst_busy", cfg_busy, 1'b0);
        chk("rst_version", cfg_version, 8'd0);
        s_axis_tdata = 12'h100; s_axis_tvalid = 1'b1; fir_tready = 1'b1;
        #1;
        chk("pass_tdata", fir_tdata, 12'h100);
        chk("pass_tvalid", fir_tvalid, 1'b1);
        chk("pass_tuser", fir_tuser, 1'b0);
        chk("pass_tready", s_axis_tready, 1'b1);

        // Shadow writes, plus an out-of-range write that must not alias
        for (int i = 0; i < 4; i++) begin
            cfg_wr_en = 1'b1; cfg_wr_addr = AW'(i); cfg_wr_data = wvals[i];
            tick();
        end
        cfg_wr_addr = 3'd5; cfg_wr_data = 12'hABC;
        tick();
        cfg_wr_en = 1'b0;
        chk("shadow_not_active", coef_flat, 48'h000_000_000_7FF);

        // Commit: the commit cycle itself still passes traffic
        cfg_commit = 1'b1;
        #1;
        chk("commit_cycle_tready", s_axis_tready, 1'b1);
        tick();
        cfg_commit = 1'b0;
        chk("swap_tvalid", fir_tvalid, 1'b0);
        chk("swap_coef_old", coef_flat, 48'h000_000_000_7FF);
        n = 0; beats = 0;
        while (cfg_busy && n < 20) begin
            n++;
            if (fir_tvalid && fir_tuser && fir_tdata == '0) beats++;
            chk("busy_tready", s_axis_tready, 1'b0);
            tick();
        end
        chk("busy_cycles", n, 4);
        chk("flush_beats", beats, 3);
        chk("new_coef", coef_flat, 48'h400_300_200_100);
        chk("version1", cfg_version, 8'd1);

        // Same-cycle write+commit, backpressure and commit during FLUSH
        cfg_wr_en = 1'b1; cfg_wr_addr = 3'd2; cfg_wr_data = 12'h7FF; cfg_commit = 1'b1;
        tick();
        cfg_wr_en = 1'b0; cfg_commit = 1'b0;
        tick();
        chk("wc_coef", coef_flat, 48'h400_7FF_200_100);
        chk("version2", cfg_version, 8'd2);
        fir_tready = 1'b0; cfg_commit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_tvalid", fir_tvalid, 1'b1);
            chk("bp_tuser", fir_tuser, 1'b1);
            chk("bp_tready", s_axis_tready, 1'b0);
            tick();
            cfg_commit = 1'b0;
        end
        fir_tready = 1'b1;
        n = 0; hs = 0;
        while (cfg_busy && n < 20) begin
            n++;
            if (fir_tvalid && fir_tready) hs++;
            tick();
        end
        chk("bp_handshakes", hs, 3);
        chk("bp_version", cfg_version, 8'd2);
        chk("bp_resume_tdata", fir_tdata, 12'h100);

        // Reset mid-FLUSH after one zero beat
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        tick();
        tick();
        chk("midflush_busy", cfg_busy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rstflush_busy", cfg_busy, 1'b0);
        chk("rstflush_coef", coef_flat, 48'h000_000_000_7FF);
        chk("rstflush_version", cfg_version, 8'd0);
        rst_n = 1'b1;
        tick();

        // FLUSH_EN=0: busy exactly one cycle per commit
        c0_commit = 1'b1;
        tick();
        c0_commit = 1'b0;
        chk("nf_busy", c0_busy, 1'b1);
        chk("nf_tvalid", c0_fir_tvalid, 1'b0);
        tick();
        chk("nf_busy_done", c0_busy, 1'b0);
        chk("nf_version", c0_version, 8'd1);
        chk("nf_tready", c0_s_tready, 1'b1);

        // Version wrap over 256 commits
        for (int i = 1; i <= 256; i++) begin
            cfg_commit = 1'b1;
            tick();
            cfg_commit = 1'b0;
            n = 0;
            while (cfg_busy && n < 20) begin
                n++;
                tick();
            end
            if (i == 255) chk("version255", cfg_version, 8'd255);
        end
        chk("version_wrap", cfg_version, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
